// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache pmem arbiter: FSM encodings, request
// bundle type and the request-detect helper.
package dcache_pkg;

    localparam int PMEM_LEN_W = 8;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_CMD  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    typedef struct packed {
        logic [3:0]            wr;
        logic                  rd;
        logic [PMEM_LEN_W-1:0] len;
        logic [31:0]           addr;
        logic [31:0]           data;
    } pmem_req_t;

    function automatic logic is_req(input logic [3:0] wr, input logic rd);
        return rd | (|wr);
    endfunction

endpackage

// File: rtl/dcache_pmem_mux.sv
// Request mux toward the AXI bridge plus response steering back to the
// requester that owns the current transaction.
import dcache_pkg::*;

module dcache_pmem_mux (
    input  logic      sel,
    input  logic      fwd_en,
    input  logic      rd_en,
    input  pmem_req_t req0,
    input  pmem_req_t req1,
    output pmem_req_t out,
    input  logic      resp_sel,
    input  logic      resp_ack,
    input  logic      resp_error,
    output logic      ack0,
    output logic      ack1,
    output logic      error0,
    output logic      error1
);

    pmem_req_t sel_req_s;

    // Mirror the selected requester; strobes are suppressed when not forwarding
    always_comb begin
        sel_req_s = sel ? req1 : req0;
        out       = sel_req_s;
        if (!fwd_en) begin
            out.wr = 4'd0;
            out.rd = 1'b0;
        end else if (!rd_en) begin
            out.rd = 1'b0;
        end else begin
            out.rd = sel_req_s.rd;
        end
    end

    assign ack0   = resp_ack & ~resp_sel;
    assign ack1   = resp_ack & resp_sel;
    assign error0 = resp_error & ~resp_sel;
    assign error1 = resp_error & resp_sel;

endmodule

// File: rtl/dcache_pmem_arb.sv
// Burst-locking two-requester arbiter for the dcache pmem port.
// Optional watchdog enabled with macro DCACHE_PMEM_ARB_TIMEOUT_EN.
import dcache_pkg::*;

module dcache_pmem_arb #(
    parameter bit          DEFAULT_PRIO   = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  inport0_wr_i,
    input  logic        inport0_rd_i,
    input  logic [7:0]  inport0_len_i,
    input  logic [31:0] inport0_addr_i,
    input  logic [31:0] inport0_write_data_i,
    output logic        inport0_accept_o,
    output logic        inport0_ack_o,
    output logic        inport0_error_o,
    output logic [31:0] inport0_read_data_o,
    input  logic [3:0]  inport1_wr_i,
    input  logic        inport1_rd_i,
    input  logic [7:0]  inport1_len_i,
    input  logic [31:0] inport1_addr_i,
    input  logic [31:0] inport1_write_data_i,
    output logic        inport1_accept_o,
    output logic        inport1_ack_o,
    output logic        inport1_error_o,
    output logic [31:0] inport1_read_data_o,
    output logic [3:0]  outport_wr_o,
    output logic        outport_rd_o,
    output logic [7:0]  outport_len_o,
    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_write_data_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic        outport_error_i,
    input  logic [31:0] outport_read_data_i,
    output logic        grant_o,
    output logic        busy_o
);

    logic [1:0]            state_r;
    logic                  owner_r;
    logic                  last_grant_r;
    logic [PMEM_LEN_W-1:0] beat_cnt_r;
    logic [PMEM_LEN_W:0]   resp_cnt_r;

    logic                  req0_s;
    logic                  req1_s;
    logic                  winner_s;
    logic                  win_req_s;
    logic                  win_is_wr_s;
    logic [PMEM_LEN_W-1:0] win_len_s;
    logic                  fwd_en_s;
    logic                  accept_s;
    logic                  timeout_s;
    logic                  route_ack_s;
    logic                  route_err_s;
    pmem_req_t             req0_bus_s;
    pmem_req_t             req1_bus_s;
    pmem_req_t             out_bus_s;

    assign req0_s = is_req(inport0_wr_i, inport0_rd_i);
    assign req1_s = is_req(inport1_wr_i, inport1_rd_i);

    // Round-robin pick in IDLE, otherwise the locked owner keeps the port
    always_comb begin
        winner_s = owner_r;
        case (state_r)
            ARB_IDLE: begin
                if (req0_s && req1_s) begin
                    winner_s = ~last_grant_r;
                end else if (req1_s) begin
                    winner_s = 1'b1;
                end else if (req0_s) begin
                    winner_s = 1'b0;
                end else begin
                    winner_s = owner_r;
                end
            end
            default: winner_s = owner_r;
        endcase
    end

    assign win_req_s   = winner_s ? req1_s : req0_s;
    assign win_is_wr_s = winner_s ? (|inport1_wr_i) : (|inport0_wr_i);
    assign win_len_s   = winner_s ? inport1_len_i : inport0_len_i;

    // Only write beats of the owner pass during CMD; nothing passes in RESP
    always_comb begin
        fwd_en_s = 1'b0;
        case (state_r)
            ARB_IDLE: fwd_en_s = win_req_s;
            ARB_CMD:  fwd_en_s = win_is_wr_s;
            default:  fwd_en_s = 1'b0;
        endcase
    end

    assign accept_s         = fwd_en_s & outport_accept_i;
    assign inport0_accept_o = accept_s & ~winner_s;
    assign inport1_accept_o = accept_s & winner_s;

`ifdef DCACHE_PMEM_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_r;
    logic        late_drop_r;

    assign timeout_s   = (state_r != ARB_IDLE) && !outport_ack_i &&
                         (wd_cnt_r == 32'(TIMEOUT_CYCLES - 32'd1));
    assign route_ack_s = (outport_ack_i & ~late_drop_r) | timeout_s;
    assign route_err_s = (outport_error_i & ~late_drop_r) | timeout_s;

    // Watchdog: restarts on any handshake; after firing, stale acks are swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r    <= 32'd0;
            late_drop_r <= 1'b0;
        end else begin
            if (outport_ack_i || accept_s || state_r == ARB_IDLE) begin
                wd_cnt_r <= 32'd0;
            end else begin
                wd_cnt_r <= wd_cnt_r + 32'd1;
            end
            if (timeout_s) begin
                late_drop_r <= 1'b1;
            end else if (accept_s) begin
                late_drop_r <= 1'b0;
            end else begin
                late_drop_r <= late_drop_r;
            end
        end
    end
`else
    assign timeout_s   = 1'b0;
    assign route_ack_s = outport_ack_i;
    assign route_err_s = outport_error_i;
`endif

    // Transaction sequencer: lock on first accept, release on last or error ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ARB_IDLE;
            owner_r      <= DEFAULT_PRIO;
            last_grant_r <= ~DEFAULT_PRIO;
            beat_cnt_r   <= 8'd0;
            resp_cnt_r   <= 9'd0;
        end else if (timeout_s) begin
            state_r    <= ARB_IDLE;
            beat_cnt_r <= 8'd0;
            resp_cnt_r <= 9'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (accept_s) begin
                        owner_r      <= winner_s;
                        last_grant_r <= winner_s;
                        if (!win_is_wr_s) begin
                            resp_cnt_r <= {1'b0, win_len_s} + 9'd1;
                            state_r    <= ARB_RESP;
                        end else if (win_len_s == 8'd0) begin
                            resp_cnt_r <= 9'd1;
                            state_r    <= ARB_RESP;
                        end else begin
                            beat_cnt_r <= win_len_s;
                            state_r    <= ARB_CMD;
                        end
                    end
                end
                ARB_CMD: begin
                    if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r - 8'd1;
                        if (beat_cnt_r == 8'd1) begin
                            resp_cnt_r <= 9'd1;
                            state_r    <= ARB_RESP;
                        end
                    end
                end
                ARB_RESP: begin
                    if (outport_ack_i) begin
                        if (outport_error_i || resp_cnt_r == 9'd1) begin
                            resp_cnt_r <= 9'd0;
                            state_r    <= ARB_IDLE;
                        end else begin
                            resp_cnt_r <= resp_cnt_r - 9'd1;
                        end
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    assign req0_bus_s = '{wr: inport0_wr_i, rd: inport0_rd_i, len: inport0_len_i,
                          addr: inport0_addr_i, data: inport0_write_data_i};
    assign req1_bus_s = '{wr: inport1_wr_i, rd: inport1_rd_i, len: inport1_len_i,
                          addr: inport1_addr_i, data: inport1_write_data_i};

    dcache_pmem_mux u_mux (
        .sel        (winner_s),
        .fwd_en     (fwd_en_s),
        .rd_en      (state_r == ARB_IDLE),
        .req0       (req0_bus_s),
        .req1       (req1_bus_s),
        .out        (out_bus_s),
        .resp_sel   (owner_r),
        .resp_ack   (route_ack_s),
        .resp_error (route_err_s),
        .ack0       (inport0_ack_o),
        .ack1       (inport1_ack_o),
        .error0     (inport0_error_o),
        .error1     (inport1_error_o)
    );

    assign outport_wr_o         = out_bus_s.wr;
    assign outport_rd_o         = out_bus_s.rd;
    assign outport_len_o        = out_bus_s.len;
    assign outport_addr_o       = out_bus_s.addr;
    assign outport_write_data_o = out_bus_s.data;

    assign inport0_read_data_o = outport_read_data_i;
    assign inport1_read_data_o = outport_read_data_i;

    assign grant_o = owner_r;
    assign busy_o  = (state_r != ARB_IDLE);

endmodule
